// File: rtl/up_down_pkg.sv
// Shared types for the up/down count monitor: FSM state encoding and the
// classification of one sampled step of the observed counter.
package up_down_pkg;

   typedef enum logic [2:0] {
      SYNC  = 3'd0,
      UP    = 3'd1,
      DOWN  = 3'd2,
      STALL = 3'd3,
      ERR   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      STEP_UP = 2'd0,
      STEP_DN = 2'd1,
      HOLD    = 2'd2,
      ILLEGAL = 2'd3
   } step_class_e;

endpackage

// File: rtl/step_classifier.sv
// Classifies the modular difference between the new sample and the previous
// one into a single up step, a single down step, a hold, or an illegal jump.
module step_classifier
   import up_down_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] prev,
   input  logic [WIDTH-1:0] count_in,
   output step_class_e      step_class
);

   logic [WIDTH-1:0] delta;

   // Subtraction wraps naturally at WIDTH bits, so max->0 reads as +1.
   assign delta = count_in - prev;

   always_comb begin
      step_class = ILLEGAL;
      if (delta == WIDTH'(1)) begin
         step_class = STEP_UP;
      end else if (delta == {WIDTH{1'b1}}) begin
         step_class = STEP_DN;
      end else if (delta == '0) begin
         step_class = HOLD;
      end
   end

endmodule

// File: rtl/up_down_count_monitor.sv
// Watches an up/down counter, decodes its direction, flags stalls and illegal
// jumps, and counts wraps in each direction.
module up_down_count_monitor
   import up_down_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int STALL_LIMIT = 8,
   parameter int WRAP_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              clr,
   output logic              dir,
   output logic              dir_valid,
   output logic              dir_change,
   output logic              stalled,
   output logic              err,
   output logic [WRAP_W-1:0] wrap_up,
   output logic [WRAP_W-1:0] wrap_dn,
   output logic [2:0]        state
);

   localparam int RUN_W = $clog2(STALL_LIMIT + 1);

   state_e             state_q;
   logic [WIDTH-1:0]   prev_q;
   logic               dir_q;
   logic               dir_valid_q;
   logic               dir_change_q;
   logic               stalled_q;
   logic               err_q;
   logic [RUN_W-1:0]   run_q;
   logic [RUN_W-1:0]   run_d;
   logic [WRAP_W-1:0]  wrap_up_q;
   logic [WRAP_W-1:0]  wrap_dn_q;
   step_class_e        step_class;

   step_classifier #(.WIDTH(WIDTH)) u_classifier (
      .prev       (prev_q),
      .count_in   (count_in),
      .step_class (step_class)
   );

   assign run_d = (run_q >= RUN_W'(STALL_LIMIT)) ? run_q : run_q + RUN_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= SYNC;
         prev_q       <= '0;
         dir_q        <= 1'b1;
         dir_valid_q  <= 1'b0;
         dir_change_q <= 1'b0;
         stalled_q    <= 1'b0;
         err_q        <= 1'b0;
         run_q        <= '0;
         wrap_up_q    <= '0;
         wrap_dn_q    <= '0;
      end else begin
         dir_change_q <= 1'b0;
         // A clear discards any same-cycle sample and restarts sync.
         if (clr) begin
            state_q     <= SYNC;
            dir_valid_q <= 1'b0;
            stalled_q   <= 1'b0;
            err_q       <= 1'b0;
            run_q       <= '0;
         end else if (en) begin
            case (state_q)
               SYNC: begin
                  prev_q  <= count_in;
                  state_q <= STALL;
               end
               UP, DOWN, STALL: begin
                  prev_q <= count_in;
                  case (step_class)
                     STEP_UP: begin
                        state_q      <= UP;
                        dir_q        <= 1'b1;
                        dir_valid_q  <= 1'b1;
                        dir_change_q <= dir_valid_q && !dir_q;
                        run_q        <= '0;
                        stalled_q    <= 1'b0;
                        if (prev_q == {WIDTH{1'b1}} && wrap_up_q != {WRAP_W{1'b1}}) begin
                           wrap_up_q <= wrap_up_q + WRAP_W'(1);
                        end
                     end
                     STEP_DN: begin
                        state_q      <= DOWN;
                        dir_q        <= 1'b0;
                        dir_valid_q  <= 1'b1;
                        dir_change_q <= dir_valid_q && dir_q;
                        run_q        <= '0;
                        stalled_q    <= 1'b0;
                        if (prev_q == '0 && wrap_dn_q != {WRAP_W{1'b1}}) begin
                           wrap_dn_q <= wrap_dn_q + WRAP_W'(1);
                        end
                     end
                     HOLD: begin
                        state_q   <= STALL;
                        run_q     <= run_d;
                        stalled_q <= (run_d >= RUN_W'(STALL_LIMIT));
                     end
                     default: begin
                        state_q     <= ERR;
                        err_q       <= 1'b1;
                        dir_valid_q <= 1'b0;
                        stalled_q   <= 1'b0;
                        run_q       <= '0;
                     end
                  endcase
               end
               default: begin
                  // ERR ignores samples until cleared.
                  state_q <= state_q;
               end
            endcase
         end
      end
   end

   assign dir        = dir_q;
   assign dir_valid  = dir_valid_q;
   assign dir_change = dir_change_q;
   assign stalled    = stalled_q;
   assign err        = err_q;
   assign wrap_up    = wrap_up_q;
   assign wrap_dn    = wrap_dn_q;
   assign state      = state_q;

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Directed bench for up_down_count_monitor with hand-computed expectations.
module tb_up_down_count_monitor;

   localparam logic [2:0] S_SYNC  = 3'd0;
   localparam logic [2:0] S_UP    = 3'd1;
   localparam logic [2:0] S_DOWN  = 3'd2;
   localparam logic [2:0] S_STALL = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] count_in = 4'd0;
   logic       clr = 1'b0;
   logic       dir, dir_valid, dir_change, stalled, err;
   logic [7:0] wrap_up, wrap_dn;
   logic [2:0] state;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   up_down_count_monitor #(.WIDTH(4), .STALL_LIMIT(8), .WRAP_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .count_in   (count_in),
      .clr        (clr),
      .dir        (dir),
      .dir_valid  (dir_valid),
      .dir_change (dir_change),
      .stalled    (stalled),
      .err        (err),
      .wrap_up    (wrap_up),
      .wrap_dn    (wrap_dn),
      .state      (state)
   );

   // Drive one cycle of inputs at the falling edge, return 1ns after the rising edge.
   task automatic drive(input logic r, input logic e, input logic [3:0] c, input logic cl);
      @(negedge clk);
      rst = r; en = e; count_in = c; clr = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [3:0] c);
      drive(1'b0, 1'b1, c, 1'b0);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 4'd0, 1'b0);
      drive(1'b1, 1'b0, 4'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({state, dir, dir_valid, dir_change, stalled, err} !== {S_SYNC, 5'b10000})
         $display("FAIL reset_flags: got st=%0d dir=%b dv=%b dc=%b stl=%b err=%b, want st=0 dir=1 others 0",
                  state, dir, dir_valid, dir_change, stalled, err);
      else passed++;
      checks++;
      if ({wrap_up, wrap_dn} !== 16'h0000)
         $display("FAIL reset_wraps: got up=%0d dn=%0d, want 0 0", wrap_up, wrap_dn);
      else passed++;
   endtask

   task automatic test_basic_up();
      do_reset();
      sample(4'd3);
      checks++;
      if ({state, dir_valid} !== {S_STALL, 1'b0})
         $display("FAIL basic_sync: got st=%0d dv=%b, want st=3 dv=0", state, dir_valid);
      else passed++;
      sample(4'd4);
      sample(4'd5);
      checks++;
      if ({state, dir, dir_valid, err} !== {S_UP, 3'b110})
         $display("FAIL basic_up: got st=%0d dir=%b dv=%b err=%b, want st=1 dir=1 dv=1 err=0",
                  state, dir, dir_valid, err);
      else passed++;
   endtask

   task automatic test_wrap_and_reverse();
      do_reset();
      sample(4'd14); sample(4'd15); sample(4'd0);
      checks++;
      if ({wrap_up, wrap_dn} !== {8'd1, 8'd0})
         $display("FAIL wrap_up_first: got up=%0d dn=%0d, want 1 0", wrap_up, wrap_dn);
      else passed++;
      sample(4'd1);
      sample(4'd1);
      checks++;
      if ({state, dir, dir_change} !== {S_STALL, 2'b10})
         $display("FAIL hold_keeps_dir: got st=%0d dir=%b dc=%b, want st=3 dir=1 dc=0", state, dir, dir_change);
      else passed++;
      sample(4'd0);
      checks++;
      if ({state, dir, dir_change, wrap_dn} !== {S_DOWN, 2'b01, 8'd0})
         $display("FAIL reverse_pulse: got st=%0d dir=%b dc=%b dn=%0d, want st=2 dir=0 dc=1 dn=0",
                  state, dir, dir_change, wrap_dn);
      else passed++;
      sample(4'd15);
      checks++;
      if ({dir, dir_change, wrap_up, wrap_dn} !== {2'b00, 8'd1, 8'd1})
         $display("FAIL wrap_dn_first: got dir=%b dc=%b up=%0d dn=%0d, want dir=0 dc=0 up=1 dn=1",
                  dir, dir_change, wrap_up, wrap_dn);
      else passed++;
   endtask

   task automatic test_stall();
      do_reset();
      sample(4'd6); sample(4'd7);
      for (int i = 1; i <= 9; i++) begin
         drive(1'b0, 1'b0, 4'd2, 1'b0);
         sample(4'd7);
         checks++;
         if ({state, stalled} !== {S_STALL, (i >= 8)})
            $display("FAIL stall_run_%0d: got st=%0d stalled=%b, want st=3 stalled=%b", i, state, stalled, (i >= 8));
         else passed++;
      end
      sample(4'd8);
      checks++;
      if ({state, stalled, dir_change, dir} !== {S_UP, 3'b001})
         $display("FAIL stall_release: got st=%0d stalled=%b dc=%b dir=%b, want st=1 stalled=0 dc=0 dir=1",
                  state, stalled, dir_change, dir);
      else passed++;
   endtask

   task automatic test_en_freeze();
      do_reset();
      sample(4'd4); sample(4'd3);
      drive(1'b0, 1'b0, 4'd2, 1'b0);
      drive(1'b0, 1'b0, 4'd11, 1'b0);
      checks++;
      if ({state, dir, dir_change} !== {S_DOWN, 2'b00})
         $display("FAIL en_freeze: got st=%0d dir=%b dc=%b, want st=2 dir=0 dc=0", state, dir, dir_change);
      else passed++;
      sample(4'd2);
      checks++;
      if ({state, err} !== {S_DOWN, 1'b0})
         $display("FAIL en_prev_kept: got st=%0d err=%b, want st=2 err=0", state, err);
      else passed++;
   endtask

   task automatic test_err();
      do_reset();
      sample(4'd2); sample(4'd3); sample(4'd9);
      checks++;
      if ({state, err, dir_valid} !== {S_ERR, 2'b10})
         $display("FAIL err_enter: got st=%0d err=%b dv=%b, want st=4 err=1 dv=0", state, err, dir_valid);
      else passed++;
      sample(4'd10);
      checks++;
      if ({state, err} !== {S_ERR, 1'b1})
         $display("FAIL err_ignores: got st=%0d err=%b, want st=4 err=1", state, err);
      else passed++;
      drive(1'b0, 1'b1, 4'd6, 1'b1);
      checks++;
      if ({state, err, dir_valid} !== {S_SYNC, 2'b00})
         $display("FAIL err_clr: got st=%0d err=%b dv=%b, want st=0 err=0 dv=0", state, err, dir_valid);
      else passed++;
      sample(4'd7);
      checks++;
      if ({state, dir_valid} !== {S_STALL, 1'b0})
         $display("FAIL err_resync: got st=%0d dv=%b, want st=3 dv=0", state, dir_valid);
      else passed++;
      sample(4'd8);
      checks++;
      if ({state, dir_valid} !== {S_UP, 1'b1})
         $display("FAIL err_recover: got st=%0d dv=%b, want st=1 dv=1", state, dir_valid);
      else passed++;
   endtask

   task automatic test_clr_nonerr();
      do_reset();
      sample(4'd15); sample(4'd0);
      for (int i = 0; i < 8; i++) sample(4'd0);
      checks++;
      if ({stalled, wrap_up} !== {1'b1, 8'd1})
         $display("FAIL clr_pre: got stalled=%b up=%0d, want 1 1", stalled, wrap_up);
      else passed++;
      drive(1'b0, 1'b1, 4'd9, 1'b1);
      checks++;
      if ({state, stalled, dir_valid, wrap_up} !== {S_SYNC, 2'b00, 8'd1})
         $display("FAIL clr_sync: got st=%0d stalled=%b dv=%b up=%0d, want st=0 0 0 up=1",
                  state, stalled, dir_valid, wrap_up);
      else passed++;
      sample(4'd9);
      for (int i = 0; i < 7; i++) sample(4'd9);
      checks++;
      if (stalled !== 1'b0)
         $display("FAIL clr_run_cleared: got stalled=%b after 7 holds, want 0", stalled);
      else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      sample(4'd15); sample(4'd0);
      for (int k = 0; k < 2; k++)
         for (int v = 1; v <= 16; v++) sample(4'(v));
      sample(4'd1); sample(4'd2);
      checks++;
      if ({state, wrap_up} !== {S_UP, 8'd3})
         $display("FAIL mid_pre: got st=%0d up=%0d, want st=1 up=3", state, wrap_up);
      else passed++;
      drive(1'b1, 1'b1, 4'd3, 1'b1);
      checks++;
      if ({state, dir, dir_valid, dir_change, stalled, err, wrap_up, wrap_dn} !== {S_SYNC, 5'b10000, 16'h0000})
         $display("FAIL mid_reset: got st=%0d dir=%b dv=%b dc=%b stl=%b err=%b up=%0d dn=%0d, want reset values",
                  state, dir, dir_valid, dir_change, stalled, err, wrap_up, wrap_dn);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      sample(4'd9);
      checks++;
      if ({state, dir_valid, err} !== {S_STALL, 2'b00})
         $display("FAIL mid_resync: got st=%0d dv=%b err=%b, want st=3 dv=0 err=0", state, dir_valid, err);
      else passed++;
      sample(4'd10);
      checks++;
      if ({state, dir_valid} !== {S_UP, 1'b1})
         $display("FAIL mid_recover: got st=%0d dv=%b, want st=1 dv=1", state, dir_valid);
      else passed++;
   endtask

   task automatic test_wrap_saturate();
      do_reset();
      sample(4'd0);
      for (int k = 0; k < 260; k++)
         for (int v = 1; v <= 16; v++) sample(4'(v));
      checks++;
      if ({wrap_up, wrap_dn} !== {8'd255, 8'd0})
         $display("FAIL wrap_sat: got up=%0d dn=%0d, want 255 0", wrap_up, wrap_dn);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic_up();
      test_wrap_and_reverse();
      test_stall();
      test_en_freeze();
      test_err();
      test_clr_nonerr();
      test_reset_mid();
      test_wrap_saturate();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/up_down_count_monitor.md
UP_DOWN_COUNT_MONITOR -- requirements
Module: up_down_count_monitor

Interface
REQ-001 Parameter WIDTH, default 4: width of observed count.
REQ-002 Parameter STALL_LIMIT, default 8: consecutive hold samples before stall is flagged.
REQ-003 Parameter WRAP_W, default 8: width of wrap counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  sample qualifier; count_in is sampled only when en=1.
REQ-007 count_in  input  WIDTH  count value driven by the up/down counter under observation.
REQ-008 clr  input  1  one-cycle request to leave ERR and resync.
REQ-009 dir  output  1  decoded direction: 1=up, 0=down.
REQ-010 dir_valid  output  1  high once at least one legal step has been decoded since sync.
REQ-011 dir_change  output  1  one-cycle pulse on decoded direction reversal.
REQ-012 stalled  output  1  high while hold run length >= STALL_LIMIT.
REQ-013 err  output  1  high while in ERR.
REQ-014 wrap_up  output  WRAP_W  count of up-wraps (max->0), saturating.
REQ-015 wrap_dn  output  WRAP_W  count of down-wraps (0->max), saturating.
REQ-016 state  output  3  current FSM state encoding, for debug.

Function
REQ-017 The block SHALL register prev (last sampled count) and classify each enabled sample by delta = (count_in - prev) mod 2^WIDTH: 1=STEP_UP, 2^WIDTH-1=STEP_DN, 0=HOLD, other=ILLEGAL.
REQ-018 FSM states SHALL be SYNC, UP, DOWN, STALL, ERR.
REQ-019 SYNC: the first enabled sample SHALL only load prev and move to STALL without classification, leaving dir_valid at 0.
REQ-020 From UP/DOWN/STALL, an enabled sample SHALL go to UP on STEP_UP, DOWN on STEP_DN, STALL on HOLD, ERR on ILLEGAL.
REQ-021 ERR SHALL hold until clr=1, then go to SYNC; samples in ERR are ignored and prev is not updated.
REQ-022 On STEP_UP/STEP_DN: dir SHALL take 1/0, dir_valid SHALL set to 1; dir_change SHALL pulse if dir_valid was already 1 and dir flips.
REQ-023 HOLD SHALL retain dir; the direction before a stall is the reference for dir_change after it.
REQ-024 Hold-run counter SHALL increment per enabled HOLD sample, saturate at STALL_LIMIT, clear on any step; stalled = (run >= STALL_LIMIT).
REQ-025 STEP_UP with prev=2^WIDTH-1 SHALL increment wrap_up; STEP_DN with prev=0 SHALL increment wrap_dn; both saturate at 2^WRAP_W-1.
REQ-026 All outputs SHALL be registered; effects of a sample at edge N are visible after edge N.
REQ-027 en=0 SHALL freeze all state, prev, and counters; dir_change SHALL be 0.
REQ-028 clr in any state other than ERR SHALL also force SYNC and clear dir_valid, run counter, and stalled; wrap counters are kept.
REQ-029 clr and an enabled sample in the same cycle: clr SHALL win and the sample SHALL be discarded.
REQ-030 Entering ERR SHALL clear dir_valid and stalled; wrap counters SHALL be kept.

Reset
REQ-031 rst=1 at a rising edge SHALL set state=SYNC, prev=0, dir=1, dir_valid=0, dir_change=0, stalled=0, err=0, run=0, wrap_up=0, wrap_dn=0.
REQ-032 rst SHALL override en and clr; reset mid-stream SHALL discard the in-flight sample.

Structure
REQ-033 The state enum and the step-class constants (STEP_UP, STEP_DN, HOLD, ILLEGAL) SHALL live in shared package up_down_pkg.
REQ-034 Delta classification SHALL be a combinational sub-module step_classifier (inputs prev, count_in; output class).

Verification
REQ-035 Reset, en=1, count_in 3,4,5 -> after 3rd sample state=UP, dir=1, dir_valid=1, err=0.
REQ-036 Up stream 14,15,0,1 -> wrap_up=1, wrap_dn=0; then 1,0,15 -> dir=0, dir_change single pulse at sample 0, wrap_dn=1.
REQ-037 Hold at 7 for 9 enabled samples (en toggling 0/1 between) -> stalled=1 only after the 8th enabled HOLD; next 8 -> stalled=0, state=UP.
REQ-038 Stream 2,3,9 -> state=ERR, err=1, dir_valid=0; further samples ignored; clr=1 with en=1 same cycle -> SYNC, sample discarded.
REQ-039 Mid-stream rst=1 for one cycle during up-count with wrap_up=3 -> all outputs at REQ-031 values next cycle; first subsequent sample only loads prev.
